branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter: BHT_ENTRIES, 64, number of 2-bit history counters (power of two, 4..1024).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: if_pc  in  32  fetch-stage PC used for prediction lookup.
REQ-005 SHALL have port: if_pred_taken  out  1  prediction for the instruction at if_pc.
REQ-006 SHALL have port: id_valid  in  1  decode stage holds a valid instruction.
REQ-007 SHALL have port: id_branch  in  1  decode instruction is a conditional branch (beq/bne/bgtz/blez/bgez/bltz/bgezal/bltzal).
REQ-008 SHALL have port: id_pc  in  32  PC of the decode instruction.
REQ-009 SHALL have port: id_pred_taken  in  1  prediction carried down with the decode instruction.
REQ-010 SHALL have port: id_target  in  32  computed branch target.
REQ-011 SHALL have port: opnd_ready  in  1  branch source operands are forwarded and valid.
REQ-012 SHALL have port: cmp_taken  in  1  branch-condition result from the decode-stage comparator.
REQ-013 SHALL have port: id_stall  out  1  hold IF/ID registers.
REQ-014 SHALL have port: redirect_valid  out  1  one-cycle fetch redirect.
REQ-015 SHALL have port: redirect_pc  out  32  PC fetch must resume from.
REQ-016 SHALL have port: perf_mispred  out  32  mispredict count.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_OPND, REDIR.
REQ-018 SHALL, in IDLE with id_valid & id_branch & !opnd_ready, assert id_stall combinationally and go to WAIT_OPND.
REQ-019 SHALL, in WAIT_OPND, keep id_stall=1 while opnd_ready=0, with no bound on wait length.
REQ-020 SHALL resolve a branch in the cycle it is valid in IDLE or WAIT_OPND with opnd_ready=1: actual = cmp_taken.
REQ-021 SHALL, on resolve with actual != id_pred_taken, go to REDIR and increment perf_mispred; otherwise return to or stay in IDLE.
REQ-022 SHALL, in REDIR, drive redirect_valid=1 for exactly one cycle, registered. redirect_pc = id_target if actual, else resolving id_pc+8 (past delay slot). Then go to IDLE unconditionally.
REQ-023 SHALL, in REDIR, ignore id_branch: the ID instruction is the delay slot; no stall, no resolve, no update.
REQ-024 SHALL keep id_stall=0 and redirect_valid=0 when id_valid=0 or id_branch=0.
REQ-025 SHALL saturate perf_mispred at 32'hFFFF_FFFF; no wrap-around.
REQ-026 SHALL compute id_pc+8 modulo 2^32.

Reset
REQ-027 SHALL, on resetn=0, immediately force state IDLE, redirect_valid=0, redirect_pc=0, perf_mispred=0, and every history counter to 2'b01.
REQ-028 SHALL drop a pending redirect or wait if reset asserts mid-operation; id_stall=0 during reset.

Configuration
REQ-029 SHALL, with BRANCH_PRED_EN defined, hold BHT_ENTRIES 2-bit saturating counters indexed by pc[log2(BHT_ENTRIES)+1:2]. Each resolve increments (taken) or decrements (not taken) counter[id_pc index], saturating at 3 and 0. if_pred_taken = counter[if_pc index][1].
REQ-030 SHALL read the old counter value on if_pc when a same-cycle update hits the same index (no bypass).
REQ-031 SHALL, without BRANCH_PRED_EN, omit the table, tie if_pred_taken=0 (static not-taken), keep all FSM/redirect/counter behaviour.

Structure
REQ-032 SHALL define FSM state encodings and the branch opcode constants in the shared CPU definitions package.
REQ-033 SHALL place the counter table in one sub-module, bht, instantiated only under BRANCH_PRED_EN.

Verification
REQ-034 SHALL cover: reset, then branch at id_pc=0x100, pred=0, cmp_taken=1, target=0x200 -> redirect_valid pulse 1 cycle later, redirect_pc=0x200, perf_mispred=1.
REQ-035 SHALL cover: pred=1, cmp_taken=0, id_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0004 (wrap).
REQ-036 SHALL cover: opnd_ready low 3 cycles -> id_stall high exactly 3 cycles, resolve on 4th.
REQ-037 SHALL cover: BRANCH_PRED_EN, pc=0x40 taken 2x from reset -> if_pred_taken(0x40) goes 0 then 1; two not-taken -> back to 0.
REQ-038 SHALL cover: resetn pulled low during REDIR -> redirect_valid=0 immediately, state IDLE, counters 2'b01.
REQ-039 SHALL cover: perf_mispred preloaded at 0xFFFF_FFFF via forced state plus a mispredict -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared CPU definitions for the decode-stage branch controller: FSM encodings,
// conditional-branch opcodes, and small helpers for the history table and redirect math.
package branch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_OPND = 2'd1;
  localparam logic [1:0] ST_REDIR     = 2'd2;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        taken;
  } bht_upd_t;

  function automatic logic is_cond_branch(input logic [5:0] opcode, input logic [4:0] rt);
    logic regimm_br;
    regimm_br = (rt == RT_BLTZ) || (rt == RT_BGEZ) || (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
    return (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLEZ) ||
           (opcode == OP_BGTZ) || ((opcode == OP_REGIMM) && regimm_br);
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != 2'b11)) nxt = cnt + 2'b01;
    if (!taken && (cnt != 2'b00)) nxt = cnt - 2'b01;
    return nxt;
  endfunction

  // Resume point past the delay slot; wraps naturally at 2^32.
  function automatic logic [31:0] pc_after_slot(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// Branch history table of 2-bit saturating counters; read is combinational on rd_pc,
// update lands on the next rising edge, and a same-cycle read sees the old value.
module branch_ctrl_bht
  import branch_ctrl_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] rd_pc,
  output logic        rd_taken,
  input  logic        upd_vld,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int         IDX_W    = $clog2(ENTRIES);
  localparam logic [1:0] BHT_INIT = 2'b01;

  logic [1:0]       cnt_q [ENTRIES];
  logic [1:0]       cnt_d [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{rd_pc[31:IDX_W+2], rd_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

  always_comb begin
    cnt_d = cnt_q;
    if (upd_vld) cnt_d[upd_idx] = bht_next(cnt_q[upd_idx], upd_taken);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // No bypass: prediction reflects the table before any same-cycle update.
  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch resolver: stalls ID until operands are ready, resolves, and issues a
// registered one-cycle fetch redirect on mispredict. BRANCH_PRED_EN adds the history table.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        id_valid,
  input  logic        id_branch,
  input  logic [31:0] id_pc,
  input  logic        id_pred_taken,
  input  logic [31:0] id_target,
  input  logic        opnd_ready,
  input  logic        cmp_taken,
  output logic        id_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_mispred
);

  logic [1:0]  state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;
  logic        stall_c;
  bht_upd_t    upd;

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    perf_mispred_d   = perf_mispred_q;
    stall_c          = 1'b0;
    upd.vld          = 1'b0;
    upd.pc           = id_pc;
    upd.taken        = cmp_taken;
    case (state_q)
      ST_IDLE, ST_WAIT_OPND: begin
        state_d = ST_IDLE;
        if (id_valid && id_branch) begin
          if (!opnd_ready) begin
            stall_c = 1'b1;
            state_d = ST_WAIT_OPND;
          end else begin
            upd.vld = 1'b1;
            if (cmp_taken != id_pred_taken) begin
              state_d          = ST_REDIR;
              redirect_valid_d = 1'b1;
              redirect_pc_d    = cmp_taken ? id_target : pc_after_slot(id_pc);
              if (perf_mispred_q != PERF_MAX) perf_mispred_d = perf_mispred_q + 32'd1;
            end
          end
        end
      end
      // The instruction in ID now is the delay slot: no stall, no resolve.
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      perf_mispred_q   <= 32'h0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_mispred_q   <= perf_mispred_d;
    end
  end

  // Stall must drop while reset is held even though the FSM sees a waiting branch.
  assign id_stall       = stall_c & resetn;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign perf_mispred   = perf_mispred_q;

`ifdef BRANCH_PRED_EN
  branch_ctrl_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .resetn    (resetn),
    .rd_pc     (if_pc),
    .rd_taken  (if_pred_taken),
    .upd_vld   (upd.vld),
    .upd_pc    (upd.pc),
    .upd_taken (upd.taken)
  );
`else
  logic unused_cfg;
  assign if_pred_taken = 1'b0;
  assign unused_cfg    = ^{if_pc, upd, BHT_ENTRIES[0]};
`endif

endmodule
